// File: rtl/gsm_uart_framer_if.sv
// +----------------------------------------------------------------------------+
// | gsm_uart_framer_if : slicer burst input and UART output bundle             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gsm_uart_framer_if;
    logic [7:0] pkt_data;
    logic       pkt_busy;
    logic       tx;
    logic       tx_busy;
    logic       frame_drop;

    modport master (
        output pkt_data,
        output pkt_busy,
        input  tx,
        input  tx_busy,
        input  frame_drop
    );

    modport slave (
        input  pkt_data,
        input  pkt_busy,
        output tx,
        output tx_busy,
        output frame_drop
    );
endinterface

`default_nettype wire

// File: rtl/gsm_uart_framer.sv
// +----------------------------------------------------------------------------+
// | gsm_uart_framer : captures a slicer burst and sends it as an 8N1 UART frame|
// | Optional trailing XOR checksum byte: define UART_CHECKSUM_EN               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gsm_uart_framer #(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         SKIP         = 2,
    parameter int         PAYLOAD_LEN  = 9,
    parameter logic [7:0] HEADER       = 8'h7E
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    gsm_uart_framer_if.slave  bus
);

    localparam int                BT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int                SK_W      = $clog2(SKIP + 1);
    localparam logic [BT_W-1:0]   BT_LAST   = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [SK_W-1:0]   SKIP_LAST = SK_W'(SKIP - 1);
    localparam logic [3:0]        IDX_LAST  = 4'(PAYLOAD_LEN - 1);
`ifdef UART_CHECKSUM_EN
    localparam logic [3:0]        BYTE_LAST = 4'(PAYLOAD_LEN + 1);
`else
    localparam logic [3:0]        BYTE_LAST = 4'(PAYLOAD_LEN);
`endif

    typedef enum logic [1:0] {C_IDLE, C_SKIP, C_FILL, C_WAIT} cap_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    cap_state_t       cap_q, cap_d;
    logic [SK_W-1:0]  skip_q, skip_d;
    logic [3:0]       idx_q, idx_d;
    logic             launch_q, launch_d;
    logic             drop_q, drop_d;

    tx_state_t        txs_q, txs_d;
    logic [BT_W-1:0]  bt_q, bt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic [7:0]       buf_q [PAYLOAD_LEN];
    logic [7:0]       w_next_byte;
    logic             w_wr_en;
    logic             w_tx_done;
    logic             w_tx_blocked;

    assign w_wr_en      = (cap_q == C_FILL) && bus.pkt_busy;
    assign w_tx_done    = (txs_q == T_STOP) && (bt_q == BT_LAST) && (byte_q == BYTE_LAST);
    // The edge that ends the last stop bit is already free for a new burst.
    assign w_tx_blocked = busy_q && !w_tx_done;

    assign bus.tx         = tx_q;
    assign bus.tx_busy    = busy_q;
    assign bus.frame_drop = drop_q;

    always_comb begin
        cap_d    = cap_q;
        skip_d   = skip_q;
        idx_d    = idx_q;
        launch_d = 1'b0;
        drop_d   = 1'b0;
        case (cap_q)
            C_IDLE: begin
                if (bus.pkt_busy) begin
                    if (w_tx_blocked) begin
                        drop_d = 1'b1;
                        cap_d  = C_WAIT;
                    end else begin
                        skip_d = SK_W'(1);
                        cap_d  = C_SKIP;
                    end
                end
            end
            C_SKIP: begin
                if (!bus.pkt_busy) begin
                    drop_d = 1'b1;
                    cap_d  = C_IDLE;
                end else if (skip_q == SKIP_LAST) begin
                    idx_d = 4'd0;
                    cap_d = C_FILL;
                end else begin
                    skip_d = skip_q + SK_W'(1);
                end
            end
            C_FILL: begin
                if (!bus.pkt_busy) begin
                    drop_d = 1'b1;
                    cap_d  = C_IDLE;
                end else if (idx_q == IDX_LAST) begin
                    launch_d = 1'b1;
                    cap_d    = C_WAIT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            C_WAIT: begin
                if (!bus.pkt_busy) begin
                    cap_d = C_IDLE;
                end
            end
            default: cap_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_q    <= C_IDLE;
            skip_q   <= '0;
            idx_q    <= '0;
            launch_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            cap_q    <= cap_d;
            skip_q   <= skip_d;
            idx_q    <= idx_d;
            launch_q <= launch_d;
            drop_q   <= drop_d;
        end
    end

    // A partial burst can only overwrite leading entries; every launch follows a full refill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (w_wr_en) begin
            for (int i = 0; i < PAYLOAD_LEN; i++) begin
                if (idx_q == 4'(i)) begin
                    buf_q[i] <= bus.pkt_data;
                end
            end
        end
    end

`ifdef UART_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= 8'h00;
        end else if (w_wr_en) begin
            csum_q <= (idx_q == 4'd0) ? bus.pkt_data : (csum_q ^ bus.pkt_data);
        end
    end
`endif

    // Byte that follows frame position byte_q: payload entry byte_q, else the checksum.
    always_comb begin
`ifdef UART_CHECKSUM_EN
        w_next_byte = csum_q;
`else
        w_next_byte = 8'h00;
`endif
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (byte_q == 4'(i)) begin
                w_next_byte = buf_q[i];
            end
        end
    end

    always_comb begin
        txs_d   = txs_q;
        bt_d    = bt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (txs_q)
            T_IDLE: begin
                tx_d = 1'b1;
                if (launch_q) begin
                    txs_d   = T_START;
                    bt_d    = '0;
                    byte_d  = 4'd0;
                    shreg_d = HEADER;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            T_START: begin
                if (bt_q == BT_LAST) begin
                    bt_d  = '0;
                    bit_d = 3'd0;
                    txs_d = T_DATA;
                    tx_d  = shreg_q[0];
                end else begin
                    bt_d = bt_q + BT_W'(1);
                end
            end
            T_DATA: begin
                if (bt_q == BT_LAST) begin
                    bt_d = '0;
                    if (bit_q == 3'd7) begin
                        txs_d = T_STOP;
                        tx_d  = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    bt_d = bt_q + BT_W'(1);
                end
            end
            T_STOP: begin
                if (bt_q == BT_LAST) begin
                    bt_d = '0;
                    if (byte_q == BYTE_LAST) begin
                        txs_d  = T_IDLE;
                        busy_d = 1'b0;
                        tx_d   = 1'b1;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        shreg_d = w_next_byte;
                        txs_d   = T_START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    bt_d = bt_q + BT_W'(1);
                end
            end
            default: txs_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txs_q   <= T_IDLE;
            bt_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            txs_q   <= txs_d;
            bt_q    <= bt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gsm_uart_framer.sv
// +----------------------------------------------------------------------------+
// | tb_gsm_uart_framer : burst vectors in, decoded UART frames checked         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_gsm_uart_framer;

    localparam int CPB = 16;
    localparam int SKP = 2;
    localparam int PL  = 9;
`ifdef UART_CHECKSUM_EN
    localparam int NB  = PL + 2;
`else
    localparam int NB  = PL + 1;
`endif
    localparam int FRAME_CYC = 10 * NB * CPB;

    localparam logic [111:0] V0 = {8'hEE, 8'hDD, 8'hCC, 8'h88, 8'h77, 8'h66, 8'h55,
                                   8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'hA5, 8'h5A};
    localparam logic [111:0] V2 = {8'h3C, 8'h3C, 8'h3C, 8'hA5, 8'h5A, 8'hE7, 8'h7E,
                                   8'h01, 8'h80, 8'hFF, 8'h00, 8'hC3, 8'hFF, 8'h00};
    localparam logic [111:0] V3 = {8'hF1, 8'hF2, 8'hF3, 8'h99, 8'h88, 8'h77, 8'h66,
                                   8'h55, 8'h44, 8'h33, 8'h22, 8'h10, 8'h0F, 8'hF0};

    typedef struct {
        int           n;
        logic [111:0] d;
        bit           frame;
        int           drops;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    gsm_uart_framer_if bus ();

    gsm_uart_framer #(
        .CLKS_PER_BIT (CPB),
        .SKIP         (SKP),
        .PAYLOAD_LEN  (PL),
        .HEADER       (8'h7E)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    bit         stop_q[$];
    int         busy_lens[$];
    int         drop_cnt  = 0;
    int         drop_wide = 0;

    initial begin : mon_busy
        int run;
        run = 0;
        forever begin
            @(negedge clock);
            if (bus.tx_busy) begin
                run++;
            end else if (run > 0) begin
                busy_lens.push_back(run);
                run = 0;
            end
        end
    end

    initial begin : mon_drop
        int r;
        r = 0;
        forever begin
            @(negedge clock);
            if (bus.frame_drop) begin
                r++;
                if (r == 1) drop_cnt++;
                if (r > 1)  drop_wide++;
            end else begin
                r = 0;
            end
        end
    end

    // UART receiver sampling at mid-bit; a byte interrupted by reset is discarded.
    initial begin : mon_uart
        logic [7:0] b;
        bit         ok;
        bit         st;
        bit         sp;
        forever begin
            @(negedge clock);
            if (reset_n && (bus.tx == 1'b0)) begin
                ok = 1'b1;
                for (int i = 0; i < CPB/2 - 1; i++) begin
                    @(negedge clock);
                    if (!reset_n) ok = 1'b0;
                end
                st = bus.tx;
                for (int j = 0; j < 8; j++) begin
                    for (int i = 0; i < CPB; i++) begin
                        @(negedge clock);
                        if (!reset_n) ok = 1'b0;
                    end
                    b[j] = bus.tx;
                end
                for (int i = 0; i < CPB; i++) begin
                    @(negedge clock);
                    if (!reset_n) ok = 1'b0;
                end
                sp = bus.tx;
                if (ok) begin
                    rx_q.push_back(b);
                    stop_q.push_back(sp && !st);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic burst(input int n, input logic [111:0] d);
        for (int i = 0; i < n; i++) begin
            bus.pkt_busy = 1'b1;
            bus.pkt_data = d[i*8 +: 8];
            @(posedge clock);
            #1;
        end
        bus.pkt_busy = 1'b0;
        bus.pkt_data = 8'h00;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        stop_q.delete();
        busy_lens.delete();
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while ((busy_lens.size() < target) && (t < FRAME_CYC + 400)) begin
            @(negedge clock);
            t++;
        end
        chk("frame_done", busy_lens.size(), target);
    endtask

    function automatic logic [7:0] exp_byte(input logic [111:0] d, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k == 0)  return 8'h7E;
        if (k <= PL) return d[(k+1)*8 +: 8];
        for (int i = 0; i < PL; i++) x = x ^ d[(i+2)*8 +: 8];
        return x;
    endfunction

    task automatic check_frame(input logic [111:0] d, input int qoff, input int bidx);
        for (int k = 0; k < NB; k++) begin
            if (qoff + k < rx_q.size()) begin
                chk($sformatf("byte%0d", k), rx_q[qoff+k], exp_byte(d, k));
                chk($sformatf("framing%0d", k), stop_q[qoff+k], 1);
            end
        end
        if (bidx < busy_lens.size()) begin
            chk("busy_len", busy_lens[bidx], FRAME_CYC);
        end
    endtask

    initial begin : stim
        vec_t vt[7];
        int   d0;

        vt[0] = '{11, V0, 1'b1, 0};
        vt[1] = '{5,  V0, 1'b0, 1};
        vt[2] = '{11, V2, 1'b1, 0};
        vt[3] = '{14, V3, 1'b1, 0};
        vt[4] = '{1,  V2, 1'b0, 1};
        vt[5] = '{2,  V2, 1'b0, 1};
        vt[6] = '{10, V3, 1'b0, 1};

        bus.pkt_busy = 1'b0;
        bus.pkt_data = 8'h00;
        reset_n      = 1'b0;
        cycles(3);
        chk("rst_tx", bus.tx, 1);
        chk("rst_tx_busy", bus.tx_busy, 0);
        chk("rst_drop", bus.frame_drop, 0);
        reset_n = 1'b1;
        cycles(3);
        chk("idle_tx", bus.tx, 1);
        clear_mon();

        // Launch latency: tx falls on the edge after the last capture.
        burst(11, V0);
        chk("tx_at_capture", bus.tx, 1);
        chk("busy_at_capture", bus.tx_busy, 0);
        cycles(1);
        chk("tx_start", bus.tx, 0);
        chk("busy_start", bus.tx_busy, 1);
        wait_frames(1);
        chk("rx_count_first", rx_q.size(), NB);
        check_frame(V0, 0, 0);
        cycles(5);

        for (int v = 0; v < 7; v++) begin
            clear_mon();
            d0 = drop_cnt;
            burst(vt[v].n, vt[v].d);
            if (vt[v].frame) begin
                wait_frames(1);
                chk($sformatf("v%0d_rx_count", v), rx_q.size(), NB);
                check_frame(vt[v].d, 0, 0);
            end else begin
                cycles(10 * CPB);
                chk($sformatf("v%0d_no_rx", v), rx_q.size(), 0);
                chk($sformatf("v%0d_no_busy", v), busy_lens.size(), 0);
                chk($sformatf("v%0d_tx_idle", v), bus.tx, 1);
            end
            cycles(5);
            chk($sformatf("v%0d_drops", v), drop_cnt - d0, vt[v].drops);
        end

        // Second burst arriving mid-transmission is dropped.
        clear_mon();
        d0 = drop_cnt;
        burst(11, V0);
        cycles(1000);
        burst(11, V2);
        wait_frames(1);
        cycles(10 * CPB);
        chk("ovl_rx_count", rx_q.size(), NB);
        check_frame(V0, 0, 0);
        chk("ovl_frames", busy_lens.size(), 1);
        chk("ovl_drops", drop_cnt - d0, 1);

        // Reset during the 4th data byte.
        clear_mon();
        burst(11, V2);
        cycles(1);
        cycles(40 * CPB + 4 * CPB);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tx", bus.tx, 1);
        chk("mid_rst_busy", bus.tx_busy, 0);
        cycles(3);
        reset_n = 1'b1;
        cycles(20 * CPB);
        clear_mon();
        d0 = drop_cnt;
        burst(11, V0);
        wait_frames(1);
        chk("post_rst_rx_count", rx_q.size(), NB);
        check_frame(V0, 0, 0);
        chk("post_rst_drops", drop_cnt - d0, 0);
        cycles(5);

        // First burst edge on the very edge tx_busy falls is accepted.
        clear_mon();
        d0 = drop_cnt;
        burst(11, V0);
        cycles(FRAME_CYC);
        burst(11, V2);
        wait_frames(2);
        chk("edge_rx_count", rx_q.size(), 2 * NB);
        check_frame(V0, 0, 0);
        check_frame(V2, NB, 1);
        chk("edge_drops", drop_cnt - d0, 0);
        cycles(5);

        // One edge earlier the line is still busy, so the burst is dropped.
        clear_mon();
        d0 = drop_cnt;
        burst(11, V0);
        cycles(FRAME_CYC - 1);
        burst(11, V2);
        wait_frames(1);
        cycles(10 * CPB);
        chk("early_rx_count", rx_q.size(), NB);
        chk("early_frames", busy_lens.size(), 1);
        chk("early_drops", drop_cnt - d0, 1);

        chk("drop_width", drop_wide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
